// File: rtl/vidor_qdec_pkg.sv
// Shared constants and helpers for the quadrature decoder slice.
// Register map, bit positions and the decoded step type.
package vidor_qdec_pkg;

    localparam logic [1:0] REG_COUNT   = 2'd0;
    localparam logic [1:0] REG_CAPTURE = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_OVF = 0;
    localparam int ST_UNF = 1;
    localparam int ST_ERR = 2;
    localparam int ST_IDX = 3;

    localparam int CT_EN      = 0;
    localparam int CT_IDX_CLR = 1;
    localparam int CT_INV     = 2;
    localparam int CT_IRQ_EN  = 3;

    typedef enum logic [1:0] {
        STEP_ZERO = 2'b00,
        STEP_INC  = 2'b01,
        STEP_DEC  = 2'b11
    } step_t;

    // Map Gray {A,B} onto a 2-bit ring position, then step by difference.
    function automatic step_t qStep(input logic [1:0] prv,
                                    input logic [1:0] cur);
        logic [1:0] d;
        d = {cur[1], cur[1] ^ cur[0]} - {prv[1], prv[1] ^ prv[0]};
        case (d)
            2'd1:    return STEP_INC;
            2'd3:    return STEP_DEC;
            default: return STEP_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/vidor_qdec_if.sv
// Avalon-MM-style register slave bundle, read latency 1.
// Master drives address/strobes/data, slave returns registered read data.
interface vidor_qdec_if;

    logic [7:0]  iADDRESS;
    logic        iREAD;
    logic        iWRITE;
    logic [31:0] iWRITE_DATA;
    logic [31:0] oREAD_DATA;

    modport master (
        output iADDRESS, iREAD, iWRITE, iWRITE_DATA,
        input  oREAD_DATA
    );

    modport slave (
        input  iADDRESS, iREAD, iWRITE, iWRITE_DATA,
        output oREAD_DATA
    );

endinterface

// File: rtl/vidor_qdec_channel.sv
// One decoder channel: sync, glitch filter, x4 decode,
// counter, index capture and the STATUS/CTRL registers.
module vidor_qdec_channel
    import vidor_qdec_pkg::*;
#(
    parameter int pCNT_BITS   = 16,
    parameter int pFILTER_LEN = 3
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iTick,
    input  logic                 iEncA,
    input  logic                 iEncB,
    input  logic                 iEncI,
    input  logic                 iWrCount,
    input  logic                 iWrStatus,
    input  logic                 iWrCtrl,
    input  logic [31:0]          iWrData,
    output logic [pCNT_BITS-1:0] oCount,
    output logic [pCNT_BITS-1:0] oCapture,
    output logic [3:0]           oStatus,
    output logic [3:0]           oCtrl
);

    localparam logic [pCNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [pCNT_BITS-1:0] CNT_ONE = pCNT_BITS'(1);

    // Pin vectors are ordered {A, B, I}.
    logic [2:0] s1, s2, lvl, lvlNx;
    logic [pFILTER_LEN-1:0] hist [3];
    logic [pFILTER_LEN-1:0] histNx [3];
    logic init;
    logic act, err, idxRise;
    step_t step;
    logic [pCNT_BITS-1:0] cntNx, capNx;
    logic [3:0] setBits, statusNx;
    logic unusedWr;

    assign unusedWr = ^iWrData;

    always_comb begin
        lvlNx = lvl;
        for (int p = 0; p < 3; p++) begin
            histNx[p] = pFILTER_LEN'({hist[p], s2[p]});
            if (&histNx[p]) lvlNx[p] = 1'b1;
            else if (~|histNx[p]) lvlNx[p] = 1'b0;
        end
    end

    always_comb begin
        act     = iTick & ~init & oCtrl[CT_EN];
        step    = qStep(lvl[2:1], lvlNx[2:1]);
        err     = &(lvl[2:1] ^ lvlNx[2:1]);
        idxRise = lvlNx[0] & ~lvl[0];
        if (oCtrl[CT_INV]) begin
            step = (step == STEP_INC) ? STEP_DEC :
                   (step == STEP_DEC) ? STEP_INC : STEP_ZERO;
        end
        cntNx   = oCount;
        capNx   = oCapture;
        setBits = '0;
        if (act) begin
            unique case (1'b1)
                step == STEP_INC: begin
                    cntNx           = oCount + CNT_ONE;
                    setBits[ST_OVF] = (oCount == CNT_MAX);
                end
                step == STEP_DEC: begin
                    cntNx           = oCount - CNT_ONE;
                    setBits[ST_UNF] = (oCount == '0);
                end
                default: ;
            endcase
            setBits[ST_ERR] = err;
            if (idxRise) begin
                capNx           = oCount;
                setBits[ST_IDX] = 1'b1;
                if (oCtrl[CT_IDX_CLR]) begin
                    cntNx           = '0;
                    setBits[ST_OVF] = 1'b0;
                    setBits[ST_UNF] = 1'b0;
                end
            end
        end
        if (iWrCount) cntNx = iWrData[pCNT_BITS-1:0];
        statusNx = (iWrStatus ? (oStatus & ~iWrData[3:0]) : oStatus)
                 | setBits;
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            s1       <= '0;
            s2       <= '0;
            lvl      <= '0;
            init     <= 1'b1;
            for (int p = 0; p < 3; p++) hist[p] <= '0;
            oCount   <= '0;
            oCapture <= '0;
            oStatus  <= '0;
            oCtrl    <= '0;
        end else begin
            s1 <= {iEncA, iEncB, iEncI};
            s2 <= s1;
            if (iTick) begin
                init <= 1'b0;
                // First tick seeds history with the live level: no step.
                if (init) begin
                    for (int p = 0; p < 3; p++)
                        hist[p] <= {pFILTER_LEN{s2[p]}};
                    lvl <= s2;
                end else begin
                    for (int p = 0; p < 3; p++) hist[p] <= histNx[p];
                    lvl <= lvlNx;
                end
            end
            oCount   <= cntNx;
            oCapture <= capNx;
            oStatus  <= statusNx;
            if (iWrCtrl) oCtrl <= iWrData[3:0];
        end
    end

endmodule

// File: rtl/vidor_qdec.sv
// N-channel quadrature decoder: shared prescaler, channel array,
// register address decode, registered read mux and level IRQ.
module vidor_qdec
    import vidor_qdec_pkg::*;
#(
    parameter int pENCODERS       = 2,
    parameter int pCNT_BITS       = 16,
    parameter int pPRESCALER_BITS = 6,
    parameter int pFILTER_LEN     = 3
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic [pENCODERS-1:0] iENC_A,
    input  logic [pENCODERS-1:0] iENC_B,
    input  logic [pENCODERS-1:0] iENC_I,
    vidor_qdec_if.slave          bus,
    output logic                 oIRQ
);

    logic [pPRESCALER_BITS-1:0] presc;
    logic                       tick;
    logic [5:0]                 chSel;
    logic [1:0]                 regSel;
    logic [pCNT_BITS-1:0]       cnt [pENCODERS];
    logic [pCNT_BITS-1:0]       cap [pENCODERS];
    logic [3:0]                 sts [pENCODERS];
    logic [3:0]                 ctl [pENCODERS];
    logic [pENCODERS-1:0]       irqReq;
    logic [31:0]                rdNx;

    assign tick   = &presc;
    assign chSel  = bus.iADDRESS[7:2];
    assign regSel = bus.iADDRESS[1:0];

    for (genvar g = 0; g < pENCODERS; g++) begin : gCh
        logic hit;
        assign hit = bus.iWRITE && (chSel == 6'(g));

        vidor_qdec_channel #(
            .pCNT_BITS  (pCNT_BITS),
            .pFILTER_LEN(pFILTER_LEN)
        ) uCh (
            .iCLK     (iCLK),
            .iRESET   (iRESET),
            .iTick    (tick),
            .iEncA    (iENC_A[g]),
            .iEncB    (iENC_B[g]),
            .iEncI    (iENC_I[g]),
            .iWrCount (hit && regSel == REG_COUNT),
            .iWrStatus(hit && regSel == REG_STATUS),
            .iWrCtrl  (hit && regSel == REG_CTRL),
            .iWrData  (bus.iWRITE_DATA),
            .oCount   (cnt[g]),
            .oCapture (cap[g]),
            .oStatus  (sts[g]),
            .oCtrl    (ctl[g])
        );

        assign irqReq[g] = ctl[g][CT_IRQ_EN] & |sts[g];
    end

    always_comb begin
        rdNx = '0;
        for (int i = 0; i < pENCODERS; i++) begin
            if (chSel == 6'(i)) begin
                unique case (regSel)
                    REG_COUNT:   rdNx = 32'(cnt[i]);
                    REG_CAPTURE: rdNx = 32'(cap[i]);
                    REG_STATUS:  rdNx = 32'(sts[i]);
                    REG_CTRL:    rdNx = 32'(ctl[i]);
                endcase
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            presc          <= '0;
            bus.oREAD_DATA <= '0;
            oIRQ           <= 1'b0;
        end else begin
            presc <= presc + pPRESCALER_BITS'(1);
            if (bus.iREAD) bus.oREAD_DATA <= rdNx;
            oIRQ <= |irqReq;
        end
    end

endmodule

// File: tb/tb_vidor_qdec.sv
// Bench for vidor_qdec: directed scenarios plus random encoder and
// bus traffic against a tick-level behavioural model.
module tb_vidor_qdec;
    import vidor_qdec_pkg::*;

    localparam int N    = 2;
    localparam int FL   = 3;
    localparam int TICK = 64;
    localparam int MASK = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] encA = '0;
    logic [N-1:0] encB = '0;
    logic [N-1:0] encI = '0;
    logic irq;

    vidor_qdec_if bus();

    vidor_qdec #(
        .pENCODERS(N), .pCNT_BITS(16),
        .pPRESCALER_BITS(6), .pFILTER_LEN(FL)
    ) dut (
        .iCLK(clk), .iRESET(rst),
        .iENC_A(encA), .iENC_B(encB), .iENC_I(encI),
        .bus(bus.slave), .oIRQ(irq)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mCnt;
    bit mInit;
    bit armed = 0;
    logic [2:0] p1 [N];
    logic [2:0] p2 [N];
    int cntM [N];
    int capM [N];
    bit [3:0] stM [N];
    bit [3:0] ctM [N];
    bit lvlM [N][3];
    bit lastS [N][3];
    int runM [N][3];
    logic [31:0] expRd;
    logic expIrq;
    int gpos [4] = '{0, 1, 3, 2};

    function automatic logic [31:0] mRead(input logic [7:0] a);
        int ch;
        ch = int'(a[7:2]);
        if (ch >= N) return 32'd0;
        case (a[1:0])
            2'd0:    return 32'(cntM[ch]);
            2'd1:    return 32'(capM[ch]);
            2'd2:    return 32'(stM[ch]);
            default: return 32'(ctM[ch]);
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit irqN, tk;
        if (rst) begin
            armed = 1;
            mCnt = 0;
            mInit = 1;
            expRd = '0;
            expIrq = 1'b0;
            for (int c = 0; c < N; c++) begin
                p1[c] = '0; p2[c] = '0;
                cntM[c] = 0; capM[c] = 0; stM[c] = 0; ctM[c] = 0;
                for (int p = 0; p < 3; p++) begin
                    lvlM[c][p] = 0; lastS[c][p] = 0; runM[c][p] = 0;
                end
            end
        end else begin
            irqN = 0;
            for (int c = 0; c < N; c++)
                irqN |= ctM[c][CT_IRQ_EN] & (stM[c] != 0);
            if (bus.iREAD) expRd = mRead(bus.iADDRESS);
            mCnt++;
            tk = (mCnt % TICK == 0);
            for (int c = 0; c < N; c++) begin
                bit [3:0] setB;
                int nc, st, d;
                bit [1:0] oAB, nAB;
                bit oI;
                logic [2:0] smp;
                setB = 0;
                nc = cntM[c];
                if (tk) begin
                    smp = p2[c];
                    oAB = {lvlM[c][2], lvlM[c][1]};
                    oI = lvlM[c][0];
                    for (int p = 0; p < 3; p++) begin
                        if (mInit) begin
                            lvlM[c][p] = smp[p];
                            runM[c][p] = FL;
                        end else begin
                            runM[c][p] = (smp[p] == lastS[c][p]) ?
                                         runM[c][p] + 1 : 1;
                            if (runM[c][p] >= FL) lvlM[c][p] = smp[p];
                        end
                        lastS[c][p] = smp[p];
                    end
                    if (!mInit && ctM[c][CT_EN]) begin
                        nAB = {lvlM[c][2], lvlM[c][1]};
                        d = (gpos[nAB] - gpos[oAB] + 4) % 4;
                        st = (d == 1) ? 1 : (d == 3) ? -1 : 0;
                        if (d == 2) setB[ST_ERR] = 1;
                        if (ctM[c][CT_INV]) st = -st;
                        if (st == 1 && cntM[c] == MASK) setB[ST_OVF] = 1;
                        if (st == -1 && cntM[c] == 0) setB[ST_UNF] = 1;
                        nc = (cntM[c] + st) & MASK;
                        if (!oI && lvlM[c][0]) begin
                            capM[c] = cntM[c];
                            setB[ST_IDX] = 1;
                            if (ctM[c][CT_IDX_CLR]) begin
                                nc = 0;
                                setB[ST_OVF] = 0;
                                setB[ST_UNF] = 0;
                            end
                        end
                    end
                end
                if (bus.iWRITE && int'(bus.iADDRESS[7:2]) == c) begin
                    case (bus.iADDRESS[1:0])
                        2'd0: nc = int'(bus.iWRITE_DATA) & MASK;
                        2'd2: stM[c] = stM[c] & ~bus.iWRITE_DATA[3:0];
                        2'd3: ctM[c] = bus.iWRITE_DATA[3:0];
                        default: ;
                    endcase
                end
                stM[c] = stM[c] | setB;
                cntM[c] = nc;
            end
            if (tk) mInit = 0;
            for (int c = 0; c < N; c++) begin
                p2[c] = p1[c];
                p1[c] = {encA[c], encB[c], encI[c]};
            end
            expIrq = irqN;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("rdata", bus.oREAD_DATA, expRd);
            check("irq", 32'(irq), 32'(expIrq));
        end
    end

    // ---------------- stimulus helpers ----------------
    int ph [N];
    logic [1:0] gseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic hold(input int t = 4);
        repeat (t * TICK) @(negedge clk);
    endtask

    task automatic wr(input int ch, input logic [1:0] r,
                      input logic [31:0] d);
        @(negedge clk);
        bus.iADDRESS = 8'(ch * 4 + int'(r));
        bus.iWRITE_DATA = d;
        bus.iWRITE = 1'b1;
        @(negedge clk);
        bus.iWRITE = 1'b0;
    endtask

    task automatic rdA(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.iADDRESS = a;
        bus.iREAD = 1'b1;
        @(negedge clk);
        bus.iREAD = 1'b0;
        d = bus.oREAD_DATA;
    endtask

    task automatic expectReg(input string nm, input int ch,
                             input logic [1:0] r, input logic [31:0] w);
        logic [31:0] d;
        rdA(8'(ch * 4 + int'(r)), d);
        check(nm, d, w);
    endtask

    task automatic setPh(input int ch, input int p);
        ph[ch] = p;
        encA[ch] = gseq[p][1];
        encB[ch] = gseq[p][0];
    endtask

    task automatic stepEnc(input int ch, input int dir);
        @(negedge clk);
        setPh(ch, (ph[ch] + dir + 4) % 4);
        hold();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int c = 0; c < N; c++) begin
            setPh(c, 0);
            encI[c] = 1'b0;
        end
        rst = 1'b0;
        hold(2);
    endtask

    task automatic waitPreTick();
        @(negedge clk);
        while ((mCnt + 1) % TICK != 0) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        bus.iADDRESS = '0;
        bus.iREAD = 1'b0;
        bus.iWRITE = 1'b0;
        bus.iWRITE_DATA = '0;
        for (int c = 0; c < N; c++) ph[c] = 0;
        repeat (4) @(negedge clk);
        check("rst_rdata", bus.oREAD_DATA, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        expectReg("rst_count", 0, REG_COUNT, 32'd0);
        expectReg("rst_ctrl", 1, REG_CTRL, 32'd0);

        // 1: forward and reverse counting
        doReset();
        wr(0, REG_CTRL, 32'h1);
        for (int i = 0; i < 12; i++) stepEnc(0, 1);
        expectReg("t1_cnt12", 0, REG_COUNT, 32'd12);
        expectReg("t1_st0", 0, REG_STATUS, 32'd0);
        for (int i = 0; i < 5; i++) stepEnc(0, -1);
        expectReg("t1_cnt7", 0, REG_COUNT, 32'd7);

        // 2: wrap flags and W1C
        wr(0, REG_COUNT, 32'hFFFF);
        stepEnc(0, 1);
        expectReg("t2_cnt0", 0, REG_COUNT, 32'd0);
        expectReg("t2_ovf", 0, REG_STATUS, 32'd1);
        wr(0, REG_STATUS, 32'h1);
        expectReg("t2_w1c", 0, REG_STATUS, 32'd0);
        stepEnc(0, -1);
        expectReg("t2_cntmax", 0, REG_COUNT, 32'hFFFF);
        expectReg("t2_unf", 0, REG_STATUS, 32'd2);

        // 3: glitch rejection and illegal transition
        doReset();
        wr(0, REG_CTRL, 32'h1);
        @(negedge clk);
        encA[0] = 1'b1;
        hold(2);
        encA[0] = 1'b0;
        hold();
        expectReg("t3_glitch_cnt", 0, REG_COUNT, 32'd0);
        expectReg("t3_glitch_st", 0, REG_STATUS, 32'd0);
        @(negedge clk);
        setPh(0, 2);
        hold();
        expectReg("t3_err_cnt", 0, REG_COUNT, 32'd0);
        expectReg("t3_err_st", 0, REG_STATUS, 32'd4);

        // 4: index capture with and without clear
        doReset();
        wr(0, REG_CTRL, 32'h3);
        wr(0, REG_COUNT, 32'd40);
        @(negedge clk);
        setPh(0, 1);
        encI[0] = 1'b1;
        hold();
        expectReg("t4_cap", 0, REG_CAPTURE, 32'd40);
        expectReg("t4_clr", 0, REG_COUNT, 32'd0);
        expectReg("t4_idx", 0, REG_STATUS, 32'd8);
        wr(0, REG_CTRL, 32'h1);
        @(negedge clk);
        encI[0] = 1'b0;
        hold();
        wr(0, REG_COUNT, 32'd40);
        wr(0, REG_STATUS, 32'hF);
        @(negedge clk);
        setPh(0, 2);
        encI[0] = 1'b1;
        hold();
        expectReg("t4b_cap", 0, REG_CAPTURE, 32'd40);
        expectReg("t4b_cnt", 0, REG_COUNT, 32'd41);
        expectReg("t4b_idx", 0, REG_STATUS, 32'd8);

        // 5: interrupt masking and W1C/set collision
        doReset();
        wr(0, REG_CTRL, 32'h1);
        wr(1, REG_CTRL, 32'h9);
        wr(0, REG_COUNT, 32'hFFFF);
        stepEnc(0, 1);
        check("t5_irq_masked", 32'(irq), 32'd0);
        wr(1, REG_COUNT, 32'hFFFF);
        stepEnc(1, 1);
        check("t5_irq_on", 32'(irq), 32'd1);
        wr(1, REG_COUNT, 32'hFFFF);
        waitPreTick();
        @(negedge clk);
        setPh(1, 2);
        repeat (3) waitPreTick();
        bus.iADDRESS = 8'(1 * 4 + 2);
        bus.iWRITE_DATA = 32'h1;
        bus.iWRITE = 1'b1;
        @(negedge clk);
        bus.iWRITE = 1'b0;
        check("t5_irq_hold", 32'(irq), 32'd1);
        expectReg("t5_set_wins", 1, REG_STATUS, 32'd1);
        expectReg("t5_cnt1", 1, REG_COUNT, 32'd0);
        rdA(8'd8, d);
        check("t5_unmapped", d, 32'd0);

        // 6: encoder moving across a reset pulse
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            encA = N'($urandom);
            encB = N'($urandom);
            encI = N'($urandom);
        end
        for (int c = 0; c < N; c++) begin
            setPh(c, 2);
            encI[c] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        wr(0, REG_CTRL, 32'h1);
        hold();
        expectReg("t6_cnt0", 0, REG_COUNT, 32'd0);
        expectReg("t6_st0", 0, REG_STATUS, 32'd0);
        stepEnc(0, 1);
        expectReg("t6_cnt1", 0, REG_COUNT, 32'd1);

        // random traffic against the model
        doReset();
        for (int c = 0; c < N; c++)
            wr(c, REG_CTRL, 32'($urandom_range(0, 15)) | 32'h1);
        for (int it = 0; it < 160; it++) begin
            int c, a;
            c = $urandom_range(0, N - 1);
            a = $urandom_range(0, 11);
            case (a)
                0, 1, 2, 3, 4: begin
                    @(negedge clk);
                    setPh(c, (ph[c] + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4);
                end
                5: begin
                    @(negedge clk);
                    setPh(c, (ph[c] + 2) % 4);
                end
                6: begin
                    @(negedge clk);
                    encI[c] = ~encI[c];
                end
                7: wr($urandom_range(0, 2), REG_CTRL, $urandom);
                8: wr(c, REG_CTRL, 32'($urandom_range(0, 15)) | 32'h1);
                9: wr(c, REG_STATUS, 32'($urandom_range(0, 15)));
                10: wr(c, REG_COUNT, 32'($urandom_range(0, 3)) - 32'd2);
                default: wr($urandom_range(0, 2), REG_COUNT, $urandom);
            endcase
            repeat ($urandom_range(5, 200)) @(negedge clk);
            rdA(8'($urandom_range(0, 15)), d);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
